// File: rtl/mm_pkg.sv
// ============================================================================
// Module   : mm_pkg
// Purpose  : Shared FSM state encoding and default widths for the A/B feed.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int c_D_WIDTH     = 64;
    localparam int c_ADDR_WIDTH  = 16;
    localparam int c_A_NUM_WIDTH = 4;
    localparam int c_B_NUM_WIDTH = 4;
    localparam int c_K_WIDTH     = 8;
    localparam int c_RD_DELAY    = 2;

endpackage

`default_nettype wire

// File: rtl/feed_chan.sv
// ============================================================================
// Module   : feed_chan
// Purpose  : One feed channel: idx/k counters, SRAM address, read-return valid
//            pipe, FIFO write strobe. Optional stall counter (FEED_AB_STALL_CNT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module feed_chan
    import mm_pkg::*;
#(
    parameter int D_WIDTH    = c_D_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int NUM_WIDTH  = c_A_NUM_WIDTH,
    parameter int K_WIDTH    = c_K_WIDTH,
    parameter int RD_DELAY   = c_RD_DELAY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  run,
    input  logic [K_WIDTH-1:0]    k_len,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic                  almost_full,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [D_WIDTH-1:0]    rd_data,
    output logic [D_WIDTH-1:0]    fifo_data,
    output logic                  fifo_wr_en,
    output logic                  fin_next,
    output logic                  pending
`ifdef FEED_AB_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam logic [RD_DELAY-1:0] c_TAIL = RD_DELAY'(1) << (RD_DELAY - 1);

    logic [NUM_WIDTH-1:0]  r_idx;
    logic [K_WIDTH-1:0]    r_k;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_fin;
    logic [RD_DELAY-1:0]   r_vld;
    logic                  w_last;

    assign w_last     = (r_idx == '1) && (r_k == (k_len - K_WIDTH'(1)));
    assign rd_en      = run & ~r_fin & ~almost_full;
    assign rd_addr    = r_base + ADDR_WIDTH'({r_k, r_idx});
    assign fifo_wr_en = r_vld[RD_DELAY-1];
    assign fifo_data  = fifo_wr_en ? rd_data : '0;
    assign fin_next   = r_fin | (rd_en & w_last);
    // Anything still in flight other than the read leaving the pipe this cycle.
    assign pending    = |(r_vld & ~c_TAIL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_k    <= '0;
            r_base <= '0;
            r_fin  <= 1'b0;
            r_vld  <= '0;
        end else begin
            r_vld <= (r_vld << 1) | RD_DELAY'(rd_en);
            if (load) begin
                r_idx  <= '0;
                r_k    <= '0;
                r_base <= base;
                r_fin  <= 1'b0;
            end else if (rd_en) begin
                r_idx <= r_idx + NUM_WIDTH'(1);
                if (r_idx == '1) begin
                    r_k <= r_k + K_WIDTH'(1);
                end
                if (w_last) begin
                    r_fin <= 1'b1;
                end
            end
        end
    end

`ifdef FEED_AB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (load) begin
            r_stall_cnt <= '0;
        end else if (run && !r_fin && almost_full && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: rtl/feed_ab.sv
// ============================================================================
// Module   : feed_ab
// Purpose  : A/B stream source: reads A by column and B by row from SRAM and
//            writes them into the A/B FIFOs. Option: FEED_AB_STALL_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module feed_ab
    import mm_pkg::*;
#(
    parameter int D_WIDTH     = c_D_WIDTH,
    parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int A_NUM_WIDTH = c_A_NUM_WIDTH,
    parameter int B_NUM_WIDTH = c_B_NUM_WIDTH,
    parameter int K_WIDTH     = c_K_WIDTH,
    parameter int RD_DELAY    = c_RD_DELAY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [K_WIDTH-1:0]    k_len,
    input  logic [ADDR_WIDTH-1:0] base_A,
    input  logic [ADDR_WIDTH-1:0] base_B,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en_A,
    output logic [ADDR_WIDTH-1:0] rd_addr_A,
    input  logic [D_WIDTH-1:0]    rd_data_A,
    output logic                  rd_en_B,
    output logic [ADDR_WIDTH-1:0] rd_addr_B,
    input  logic [D_WIDTH-1:0]    rd_data_B,
    output logic [D_WIDTH-1:0]    data_A_FIFO_out,
    output logic                  wr_en_A_FIFO_out,
    input  logic                  almost_full_A_FIFO_in,
    output logic [D_WIDTH-1:0]    data_B_FIFO_out,
    output logic                  wr_en_B_FIFO_out,
    input  logic                  almost_full_B_FIFO_in
`ifdef FEED_AB_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt_A,
    output logic [31:0]           stall_cnt_B
`endif
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic [K_WIDTH-1:0]   r_k_len;
    logic                 w_start;
    logic                 w_run;
    logic                 w_fin_a;
    logic                 w_fin_b;
    logic                 w_pend_a;
    logic                 w_pend_b;

    assign w_start = start && (r_state == ST_IDLE);
    assign w_run   = (r_state == ST_RUN);
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (k_len != '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Leave on the cycle the last read issues so done lands at L+RD_DELAY+1.
                if (w_fin_a && w_fin_b) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!w_pend_a && !w_pend_b) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_k_len <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_start) begin
                r_k_len <= k_len;
            end
        end
    end

    feed_chan #(
        .D_WIDTH    (D_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WIDTH  (A_NUM_WIDTH),
        .K_WIDTH    (K_WIDTH),
        .RD_DELAY   (RD_DELAY)
    ) u_chan_a (
        .clk         (clk),
        .rst         (rst),
        .load        (w_start),
        .run         (w_run),
        .k_len       (r_k_len),
        .base        (base_A),
        .almost_full (almost_full_A_FIFO_in),
        .rd_en       (rd_en_A),
        .rd_addr     (rd_addr_A),
        .rd_data     (rd_data_A),
        .fifo_data   (data_A_FIFO_out),
        .fifo_wr_en  (wr_en_A_FIFO_out),
        .fin_next    (w_fin_a),
        .pending     (w_pend_a)
`ifdef FEED_AB_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt_A)
`endif
    );

    feed_chan #(
        .D_WIDTH    (D_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WIDTH  (B_NUM_WIDTH),
        .K_WIDTH    (K_WIDTH),
        .RD_DELAY   (RD_DELAY)
    ) u_chan_b (
        .clk         (clk),
        .rst         (rst),
        .load        (w_start),
        .run         (w_run),
        .k_len       (r_k_len),
        .base        (base_B),
        .almost_full (almost_full_B_FIFO_in),
        .rd_en       (rd_en_B),
        .rd_addr     (rd_addr_B),
        .rd_data     (rd_data_B),
        .fifo_data   (data_B_FIFO_out),
        .fifo_wr_en  (wr_en_B_FIFO_out),
        .fin_next    (w_fin_b),
        .pending     (w_pend_b)
`ifdef FEED_AB_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt_B)
`endif
    );

endmodule

`default_nettype wire

// File: tb/tb_feed_ab.sv
// ============================================================================
// Module   : tb_feed_ab
// Purpose  : Self-checking bench for feed_ab with a cycle-level expectation
//            model and a fixed-latency SRAM model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_feed_ab;

    localparam int D_WIDTH     = 64;
    localparam int ADDR_WIDTH  = 16;
    localparam int A_NUM_WIDTH = 2;
    localparam int B_NUM_WIDTH = 2;
    localparam int K_WIDTH     = 8;
    localparam int RD_DELAY    = 2;
    localparam int MAXC        = 256;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [K_WIDTH-1:0]    k_len = '0;
    logic [ADDR_WIDTH-1:0] base_A = '0;
    logic [ADDR_WIDTH-1:0] base_B = '0;
    logic                  busy, done;
    logic                  rd_en_A, rd_en_B;
    logic [ADDR_WIDTH-1:0] rd_addr_A, rd_addr_B;
    logic [D_WIDTH-1:0]    rd_data_A, rd_data_B;
    logic [D_WIDTH-1:0]    data_A_FIFO_out, data_B_FIFO_out;
    logic                  wr_en_A_FIFO_out, wr_en_B_FIFO_out;
    logic                  almost_full_A_FIFO_in = 1'b0;
    logic                  almost_full_B_FIFO_in = 1'b0;
`ifdef FEED_AB_STALL_CNT_EN
    logic [31:0]           stall_cnt_A, stall_cnt_B;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit af_a_pat [MAXC];
    bit af_b_pat [MAXC];

    always #5 clk = ~clk;

    feed_ab #(
        .D_WIDTH     (D_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .A_NUM_WIDTH (A_NUM_WIDTH),
        .B_NUM_WIDTH (B_NUM_WIDTH),
        .K_WIDTH     (K_WIDTH),
        .RD_DELAY    (RD_DELAY)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .k_len                 (k_len),
        .base_A                (base_A),
        .base_B                (base_B),
        .busy                  (busy),
        .done                  (done),
        .rd_en_A               (rd_en_A),
        .rd_addr_A             (rd_addr_A),
        .rd_data_A             (rd_data_A),
        .rd_en_B               (rd_en_B),
        .rd_addr_B             (rd_addr_B),
        .rd_data_B             (rd_data_B),
        .data_A_FIFO_out       (data_A_FIFO_out),
        .wr_en_A_FIFO_out      (wr_en_A_FIFO_out),
        .almost_full_A_FIFO_in (almost_full_A_FIFO_in),
        .data_B_FIFO_out       (data_B_FIFO_out),
        .wr_en_B_FIFO_out      (wr_en_B_FIFO_out),
        .almost_full_B_FIFO_in (almost_full_B_FIFO_in)
`ifdef FEED_AB_STALL_CNT_EN
        ,
        .stall_cnt_A           (stall_cnt_A),
        .stall_cnt_B           (stall_cnt_B)
`endif
    );

    function automatic logic [63:0] mem_a(input logic [15:0] a);
        return {16'hA0A0, a, ~a, a ^ 16'h3C3C};
    endfunction

    function automatic logic [63:0] mem_b(input logic [15:0] a);
        return {16'hB1B1, ~a, a ^ 16'hC3C3, a};
    endfunction

    // SRAM read ports: data appears RD_DELAY cycles after the enable, junk otherwise.
    logic [D_WIDTH-1:0] sa [RD_DELAY];
    logic [D_WIDTH-1:0] sb [RD_DELAY];

    always @(posedge clk) begin
        sa[0] <= rd_en_A ? mem_a(rd_addr_A) : {$urandom, $urandom};
        sb[0] <= rd_en_B ? mem_b(rd_addr_B) : {$urandom, $urandom};
        for (int i = 1; i < RD_DELAY; i++) begin
            sa[i] <= sa[i-1];
            sb[i] <= sb[i-1];
        end
    end

    assign rd_data_A = sa[RD_DELAY-1];
    assign rd_data_B = sb[RD_DELAY-1];

    task automatic clear_af();
        for (int i = 0; i < MAXC; i++) begin
            af_a_pat[i] = 1'b0;
            af_b_pat[i] = 1'b0;
        end
    endtask

    // Runs one job and checks every cycle against a model built from the
    // issue/write/done rules; af_*_pat[c] is the almost_full level in cycle c.
    task automatic run_job(input string name, input int kl, input logic [15:0] ba,
                           input logic [15:0] bb, input int restart_c);
        bit   iss_a [MAXC];
        bit   iss_b [MAXC];
        int   na, nb, ca, cb, la, lb, done_c, ia, ib, wa, wb;
        int   stall_a, stall_b;
        logic exp_wr;
        logic [15:0] ea;
        na = kl * (1 << A_NUM_WIDTH);
        nb = kl * (1 << B_NUM_WIDTH);
        ca = 0; cb = 0; la = 0; lb = 0; stall_a = 0; stall_b = 0;
        for (int c = 0; c < MAXC; c++) begin
            iss_a[c] = 1'b0;
            iss_b[c] = 1'b0;
            if (c >= 1 && ca < na) begin
                if (af_a_pat[c]) stall_a++;
                else begin iss_a[c] = 1'b1; ca++; la = c; end
            end
            if (c >= 1 && cb < nb) begin
                if (af_b_pat[c]) stall_b++;
                else begin iss_b[c] = 1'b1; cb++; lb = c; end
            end
        end
        done_c = (na == 0) ? 1 : ((la > lb ? la : lb) + RD_DELAY + 1);

        @(negedge clk);
        k_len  = K_WIDTH'(kl);
        base_A = ba;
        base_B = bb;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ia = 0; ib = 0; wa = 0; wb = 0;
        for (int c = 1; c <= done_c + 2; c++) begin
            almost_full_A_FIFO_in = af_a_pat[c];
            almost_full_B_FIFO_in = af_b_pat[c];
            start = (c == restart_c);
            if (c > 1 && c < done_c) begin
                k_len  = K_WIDTH'($urandom);
                base_A = 16'($urandom);
                base_B = 16'($urandom);
            end
            @(negedge clk);
            n_checks++;
            if (rd_en_A !== iss_a[c]) $display("FAIL %s rd_en_A cyc %0d: got %b exp %b", name, c, rd_en_A, iss_a[c]);
            else n_pass++;
            if (iss_a[c]) begin
                ea = ba + 16'(ia);
                n_checks++;
                if (rd_addr_A !== ea) $display("FAIL %s rd_addr_A cyc %0d: got %h exp %h", name, c, rd_addr_A, ea);
                else n_pass++;
                ia++;
            end
            n_checks++;
            if (rd_en_B !== iss_b[c]) $display("FAIL %s rd_en_B cyc %0d: got %b exp %b", name, c, rd_en_B, iss_b[c]);
            else n_pass++;
            if (iss_b[c]) begin
                ea = bb + 16'(ib);
                n_checks++;
                if (rd_addr_B !== ea) $display("FAIL %s rd_addr_B cyc %0d: got %h exp %h", name, c, rd_addr_B, ea);
                else n_pass++;
                ib++;
            end
            exp_wr = (c > RD_DELAY) ? iss_a[c-RD_DELAY] : 1'b0;
            n_checks++;
            if (wr_en_A_FIFO_out !== exp_wr) $display("FAIL %s wr_en_A cyc %0d: got %b exp %b", name, c, wr_en_A_FIFO_out, exp_wr);
            else n_pass++;
            if (exp_wr) begin
                ea = ba + 16'(wa);
                n_checks++;
                if (data_A_FIFO_out !== mem_a(ea)) $display("FAIL %s data_A cyc %0d: got %h exp %h", name, c, data_A_FIFO_out, mem_a(ea));
                else n_pass++;
                wa++;
            end
            exp_wr = (c > RD_DELAY) ? iss_b[c-RD_DELAY] : 1'b0;
            n_checks++;
            if (wr_en_B_FIFO_out !== exp_wr) $display("FAIL %s wr_en_B cyc %0d: got %b exp %b", name, c, wr_en_B_FIFO_out, exp_wr);
            else n_pass++;
            if (exp_wr) begin
                ea = bb + 16'(wb);
                n_checks++;
                if (data_B_FIFO_out !== mem_b(ea)) $display("FAIL %s data_B cyc %0d: got %h exp %h", name, c, data_B_FIFO_out, mem_b(ea));
                else n_pass++;
                wb++;
            end
            n_checks++;
            if (busy !== ((na > 0) && (c < done_c))) $display("FAIL %s busy cyc %0d: got %b exp %b", name, c, busy, (na > 0) && (c < done_c));
            else n_pass++;
            n_checks++;
            if (done !== (c == done_c)) $display("FAIL %s done cyc %0d: got %b exp %b", name, c, done, c == done_c);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        almost_full_A_FIFO_in = 1'b0;
        almost_full_B_FIFO_in = 1'b0;
`ifdef FEED_AB_STALL_CNT_EN
        n_checks++;
        if (stall_cnt_A !== 32'(stall_a)) $display("FAIL %s stall_cnt_A: got %0d exp %0d", name, stall_cnt_A, stall_a);
        else n_pass++;
        n_checks++;
        if (stall_cnt_B !== 32'(stall_b)) $display("FAIL %s stall_cnt_B: got %0d exp %0d", name, stall_cnt_B, stall_b);
        else n_pass++;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset done: got %b exp 0", done); else n_pass++;
        n_checks++; if (rd_en_A !== 1'b0) $display("FAIL reset rd_en_A: got %b exp 0", rd_en_A); else n_pass++;
        n_checks++; if (rd_en_B !== 1'b0) $display("FAIL reset rd_en_B: got %b exp 0", rd_en_B); else n_pass++;
        n_checks++; if (rd_addr_A !== 16'h0) $display("FAIL reset rd_addr_A: got %h exp 0", rd_addr_A); else n_pass++;
        n_checks++; if (rd_addr_B !== 16'h0) $display("FAIL reset rd_addr_B: got %h exp 0", rd_addr_B); else n_pass++;
        n_checks++; if (wr_en_A_FIFO_out !== 1'b0) $display("FAIL reset wr_en_A: got %b exp 0", wr_en_A_FIFO_out); else n_pass++;
        n_checks++; if (wr_en_B_FIFO_out !== 1'b0) $display("FAIL reset wr_en_B: got %b exp 0", wr_en_B_FIFO_out); else n_pass++;
        n_checks++; if (data_A_FIFO_out !== 64'h0) $display("FAIL reset data_A: got %h exp 0", data_A_FIFO_out); else n_pass++;
        n_checks++; if (data_B_FIFO_out !== 64'h0) $display("FAIL reset data_B: got %h exp 0", data_B_FIFO_out); else n_pass++;
    endtask

    task automatic test_basic();
        clear_af();
        run_job("basic", 3, 16'h0100, 16'h0200, 0);
    endtask

    task automatic test_backpressure();
        clear_af();
        for (int c = 3; c <= 6; c++) af_a_pat[c] = 1'b1;
        run_job("bp_a", 3, 16'h0100, 16'h0200, 0);
        clear_af();
    endtask

    task automatic test_kzero();
        clear_af();
        run_job("kzero", 0, 16'h0100, 16'h0200, 0);
    endtask

    task automatic test_wrap();
        clear_af();
        run_job("wrap", 1, 16'hFFFE, 16'hFFFD, 0);
    endtask

    task automatic test_restart();
        clear_af();
        run_job("restart", 3, 16'h0100, 16'h0200, 5);
    endtask

    task automatic test_rst_midjob();
        clear_af();
        @(negedge clk);
        k_len  = 8'd3;
        base_A = 16'h0340;
        base_B = 16'h0480;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid busy: got %b exp 0", busy); else n_pass++;
        n_checks++; if (rd_en_A !== 1'b0 || rd_en_B !== 1'b0) $display("FAIL rstmid rd_en: got %b%b exp 00", rd_en_A, rd_en_B); else n_pass++;
        n_checks++; if (wr_en_A_FIFO_out !== 1'b0 || wr_en_B_FIFO_out !== 1'b0) $display("FAIL rstmid wr_en: got %b%b exp 00", wr_en_A_FIFO_out, wr_en_B_FIFO_out); else n_pass++;
        n_checks++; if (rd_addr_A !== 16'h0 || rd_addr_B !== 16'h0) $display("FAIL rstmid rd_addr: got %h %h exp 0 0", rd_addr_A, rd_addr_B); else n_pass++;
        n_checks++; if (data_A_FIFO_out !== 64'h0 || data_B_FIFO_out !== 64'h0) $display("FAIL rstmid data: got %h %h exp 0 0", data_A_FIFO_out, data_B_FIFO_out); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || wr_en_A_FIFO_out !== 1'b0 || wr_en_B_FIFO_out !== 1'b0)
                $display("FAIL rstmid quiet cyc %0d: got done=%b busy=%b wrA=%b wrB=%b exp all 0", c, done, busy, wr_en_A_FIFO_out, wr_en_B_FIFO_out);
            else n_pass++;
        end
        run_job("after_rst", 3, 16'h0100, 16'h0200, 0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 5; j++) begin
            clear_af();
            for (int c = 1; c < MAXC; c++) begin
                af_a_pat[c] = ($urandom_range(0, 9) < 3);
                af_b_pat[c] = ($urandom_range(0, 9) < 3);
            end
            run_job($sformatf("rand%0d", j), $urandom_range(1, 6), 16'($urandom), 16'($urandom), 0);
        end
        clear_af();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_kzero();
        test_wrap();
        test_restart();
        test_rst_midjob();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/feed_ab.md
# feed_ab

Stream source at the head of the A/B FIFO chain that feeds the per-PE loaders. On `start`, it reads matrix A column-by-column and matrix B row-by-row from two fixed-latency SRAM read ports. It pushes one element per cycle per channel into the A and B FIFOs, throttled by FIFO `almost_full`. It is the writer/transmitter end of the FIFO protocol that the loader chain consumes via `valid`/`PASS_EN`.

## Interface
- `D_WIDTH`, 64, element width
- `ADDR_WIDTH`, 16, SRAM word address width
- `A_NUM_WIDTH`, 4, log2(S_i); elements per A column = 2^A_NUM_WIDTH
- `B_NUM_WIDTH`, 4, log2(S_j); elements per B row = 2^B_NUM_WIDTH
- `K_WIDTH`, 8, width of step count k_len
- `RD_DELAY`, 2, SRAM read latency in cycles (≥1)

Ports:
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle pulse, begin a job; ignored while `busy`
- `k_len` in K_WIDTH: number of outer-product steps; sampled on `start`
- `base_A` in ADDR_WIDTH: A base address; sampled on `start`
- `base_B` in ADDR_WIDTH: B base address; sampled on `start`
- `busy` out 1: job in progress
- `done` out 1: one-cycle pulse at job completion
- `rd_en_A` out 1: A SRAM read enable
- `rd_addr_A` out ADDR_WIDTH: A SRAM read address
- `rd_data_A` in D_WIDTH: A SRAM data, valid RD_DELAY cycles after `rd_en_A`
- `rd_en_B` out 1: B SRAM read enable
- `rd_addr_B` out ADDR_WIDTH: B SRAM read address
- `rd_data_B` in D_WIDTH: B SRAM data, valid RD_DELAY cycles after `rd_en_B`
- `data_A_FIFO_out` out D_WIDTH: A element to FIFO
- `wr_en_A_FIFO_out` out 1: A FIFO write strobe
- `almost_full_A_FIFO_in` in 1: A FIFO backpressure
- `data_B_FIFO_out` out D_WIDTH: B element to FIFO
- `wr_en_B_FIFO_out` out 1: B FIFO write strobe
- `almost_full_B_FIFO_in` in 1: B FIFO backpressure

## Operation
- Top FSM: IDLE → RUN on `start` with k_len≠0.
  - RUN → DRAIN when both channels have issued all reads.
  - DRAIN → IDLE when both read pipelines are empty; `done` pulses on this transition.
  - `start` with k_len=0: no reads; `done` pulses the cycle after `start`; `busy` stays 0.
- Channels A and B are independent; neither waits for the other.
  - Each channel holds an index counter `idx` (NUM_WIDTH bits) and a step counter `k` (K_WIDTH bits).
  - A channel issues a read in any RUN cycle where it is not finished and its `almost_full` is 0.
  - On issue, `idx++`; on `idx` wrap (all-ones→0), `k++`.
  - The channel is finished once the read with k=k_len-1 and idx=all-ones has issued.
- Addressing: `rd_addr` = base + {k, idx}, computed modulo 2^ADDR_WIDTH; wrap-around is silent.
  - Column-major A: column k occupies S_i consecutive words.
  - Row-major B: row k occupies S_j consecutive words.
- Return path: a RD_DELAY-deep valid shift register per channel.
  - `wr_en_*_FIFO_out` = valid tail.
  - `data_*_FIFO_out` = `rd_data_*`, passed combinationally with no extra register.
- Backpressure: `almost_full` only gates new issues; in-flight reads are always written.
  - System requirement: the FIFO asserts `almost_full` with ≥ RD_DELAY+1 free entries.
- Sampled configuration (k_len, bases) is held in registers; input changes during `busy` have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, all `rd_en`=0, all `wr_en`=0, `rd_addr_*`=0, `data_*_FIFO_out`=0, all counters 0, FSM=IDLE.
- `start` sampled at edge 0:
  - `busy`=1 and the first `rd_en` (if not `almost_full`) in cycle 1.
  - First `wr_en` in cycle 1+RD_DELAY.
- Unthrottled job with k_len=K: last A issue in cycle K·2^A_NUM_WIDTH.
  - `done` pulses in cycle max(K·S_i, K·S_j)+RD_DELAY+1.
  - `busy` falls in the same cycle.
- Throughput: 1 element/cycle/channel when not throttled.
- `almost_full` rising at edge n: no issue in cycle n. Reads already issued still produce `wr_en` on schedule.
- `rst` mid-job: immediate abort; pipeline contents discarded; no `done`.

## Configuration
- `FEED_AB_STALL_CNT_EN` defined:
  - Adds outputs `stall_cnt_A` and `stall_cnt_B`, 32 bits each.
  - Each counts RUN cycles in which its channel is unfinished and blocked by `almost_full`.
  - Counters clear on `start` and on `rst`, and saturate at all-ones.
- Undefined: the counters and ports are absent; behaviour is otherwise identical.

## Structure
- Shared package `mm_pkg`: FSM state enum (IDLE/RUN/DRAIN) and the default width constants.
- Sub-module `feed_chan`: contains the idx/k counters, address adder, valid shift register and optional stall counter.
  - Parameterised by NUM_WIDTH.
  - Instantiated twice, once for A and once for B.
  - The top level holds the FSM and the done/busy logic.

## Test plan
- A_NUM_WIDTH=B_NUM_WIDTH=2, k_len=3, base_A=0x100, base_B=0x200, no backpressure:
  - A writes 12 words in address order 0x100..0x10B; B writes 0x200..0x20B.
  - `done` in cycle 15.
- Same job with `almost_full_A` held high in cycles 3–6:
  - No A issues in those cycles; in-flight writes still occur.
  - B unaffected; A ordering intact; `done` delayed by 4 cycles.
- k_len=0: zero reads and zero writes; `done` pulses in cycle 1; `busy` never rises.
- base_A=0xFFFE, k_len=1, A_NUM_WIDTH=2: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `start` pulsed again mid-job: ignored; the current job completes with exactly one `done`.
- `rst` asserted mid-job:
  - All outputs return to reset values immediately; no `done`.
  - A following `start` runs a clean full job.
